// File: rtl/lieat_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : lieat_mem_arb
//  Purpose  : 2:1 arbiter sharing one memory request/response channel between
//             the IFU refill port (p0) and the LSU port (p1). An in-order
//             owner FIFO steers each response back to its requester.
//  Options  : LIEAT_MEM_ARB_RR_EN selects round-robin (default fixed, p1 first)
//  Revision : 1.0  initial release
// ============================================================================
module lieat_mem_arb #(
    parameter int OSTD = 2,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            p0_req_valid,
    output logic            p0_req_ready,
    input  logic [XLEN-1:0] p0_req_addr,
    output logic            p0_rsp_valid,
    input  logic            p0_rsp_ready,
    output logic [XLEN-1:0] p0_rsp_rdata,

    input  logic            p1_req_valid,
    output logic            p1_req_ready,
    input  logic            p1_req_ren,
    input  logic            p1_req_wen,
    input  logic [XLEN-1:0] p1_req_addr,
    input  logic [2:0]      p1_req_flag,
    input  logic [XLEN-1:0] p1_req_wdata,
    output logic            p1_rsp_valid,
    input  logic            p1_rsp_ready,
    output logic [XLEN-1:0] p1_rsp_rdata,

    output logic            m_req_valid,
    input  logic            m_req_ready,
    output logic            m_req_ren,
    output logic            m_req_wen,
    output logic [XLEN-1:0] m_req_addr,
    output logic [2:0]      m_req_flag,
    output logic [XLEN-1:0] m_req_wdata,
    input  logic            m_rsp_valid,
    output logic            m_rsp_ready,
    input  logic [XLEN-1:0] m_rsp_rdata
);

    localparam int            CW       = $clog2(OSTD + 1);
    localparam int            PW       = (OSTD > 1) ? $clog2(OSTD) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(OSTD);
    localparam logic [PW-1:0] LAST_PTR = PW'(OSTD - 1);
    localparam logic [2:0]    IFU_FLAG = 3'b010;

    logic [OSTD-1:0] owner_q;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            lock;
    logic            lock_port;

    logic            arb_port;
    logic            grant;
    logic            grant_valid;
    logic            fifo_full;
    logic            rsp_active;
    logic            head;
    logic            push;
    logic            pop;

    // ------------------------------------------------------------------------
    // Arbitration (owner encoding: 0 = IFU, 1 = LSU)
    // ------------------------------------------------------------------------
`ifdef LIEAT_MEM_ARB_RR_EN
    logic rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b1;
        end else if (push) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    always_comb begin
        arb_port = (p0_req_valid & p1_req_valid) ? rr_ptr : p1_req_valid;
    end
`else
    always_comb begin
        arb_port = p1_req_valid;
    end
`endif

    always_comb begin
        grant       = lock ? lock_port : arb_port;
        grant_valid = grant ? p1_req_valid : p0_req_valid;
        fifo_full   = (count == FULL_CNT);
    end

    // Outputs are forced idle while reset is held so the memory side never
    // sees a request that the cleared owner FIFO would not track.
    always_comb begin
        m_req_valid  = grant_valid & ~fifo_full & ~rst;
        p0_req_ready = m_req_ready & ~grant & ~fifo_full & ~rst;
        p1_req_ready = m_req_ready &  grant & ~fifo_full & ~rst;
        m_req_ren    = grant ? p1_req_ren   : 1'b1;
        m_req_wen    = grant ? p1_req_wen   : 1'b0;
        m_req_addr   = grant ? p1_req_addr  : p0_req_addr;
        m_req_flag   = grant ? p1_req_flag  : IFU_FLAG;
        m_req_wdata  = grant ? p1_req_wdata : '0;
        push         = m_req_valid & m_req_ready;
    end

    // Hold the grant on a stalled request so fields stay stable until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock      <= 1'b0;
            lock_port <= 1'b0;
        end else begin
            lock <= m_req_valid & ~m_req_ready;
            if (m_req_valid & ~m_req_ready) begin
                lock_port <= grant;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Owner FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                owner_q[wr_ptr] <= grant;
                wr_ptr          <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Response steering
    // ------------------------------------------------------------------------
    always_comb begin
        rsp_active   = (count != '0) & ~rst;
        head         = owner_q[rd_ptr];
        p0_rsp_valid = rsp_active & ~head & m_rsp_valid;
        p1_rsp_valid = rsp_active &  head & m_rsp_valid;
        p0_rsp_rdata = (rsp_active & ~head) ? m_rsp_rdata : '0;
        p1_rsp_rdata = (rsp_active &  head) ? m_rsp_rdata : '0;
        m_rsp_ready  = rsp_active & (head ? p1_rsp_ready : p0_rsp_ready);
        pop          = m_rsp_valid & m_rsp_ready;
    end

endmodule
`default_nettype wire

// File: tb/tb_lieat_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lieat_mem_arb
//  Purpose  : Directed and random self-checking bench for lieat_mem_arb against
//             a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lieat_mem_arb;

    localparam int OSTD = 2;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            p0_req_valid, p0_req_ready, p0_rsp_valid, p0_rsp_ready;
    logic [XLEN-1:0] p0_req_addr, p0_rsp_rdata;
    logic            p1_req_valid, p1_req_ready, p1_req_ren, p1_req_wen;
    logic [XLEN-1:0] p1_req_addr, p1_req_wdata, p1_rsp_rdata;
    logic [2:0]      p1_req_flag;
    logic            p1_rsp_valid, p1_rsp_ready;
    logic            m_req_valid, m_req_ready, m_req_ren, m_req_wen;
    logic [XLEN-1:0] m_req_addr, m_req_wdata, m_rsp_rdata;
    logic [2:0]      m_req_flag;
    logic            m_rsp_valid, m_rsp_ready;

    always #5 clk = ~clk;

    lieat_mem_arb #(.OSTD(OSTD), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_addr(p0_req_addr),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_ren(p1_req_ren),
        .p1_req_wen(p1_req_wen), .p1_req_addr(p1_req_addr), .p1_req_flag(p1_req_flag),
        .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
        .p1_rsp_rdata(p1_rsp_rdata),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_ren(m_req_ren),
        .m_req_wen(m_req_wen), .m_req_addr(m_req_addr), .m_req_flag(m_req_flag),
        .m_req_wdata(m_req_wdata), .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
        .m_rsp_rdata(m_rsp_rdata)
    );

    int ncmp = 0;
    int nerr = 0;

    // Reference model: queue of owners of issued-but-unanswered requests.
    int oq[$];
    bit m_lock, m_lockp, m_rr;
    bit e_g, e_mv, e_r0, e_r1, e_has, e_head, e_p0v, e_p1v, e_mrr;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compute expectations from the current inputs and compare on the falling edge.
    task automatic settle();
        bit full;
        @(negedge clk);
        full = (oq.size() >= OSTD);
        if (m_lock) e_g = m_lockp;
        else if (p0_req_valid && p1_req_valid) begin
`ifdef LIEAT_MEM_ARB_RR_EN
            e_g = m_rr;
`else
            e_g = 1'b1;
`endif
        end else e_g = p1_req_valid;
        e_mv = !rst && !full && (e_g ? p1_req_valid : p0_req_valid);
        e_r0 = !rst && !full && m_req_ready && !e_g;
        e_r1 = !rst && !full && m_req_ready &&  e_g;
        chk("m_req_valid", m_req_valid, e_mv);
        chk("p0_req_ready", p0_req_ready, e_r0);
        chk("p1_req_ready", p1_req_ready, e_r1);
        if (e_mv) begin
            chk("m_req_addr",  m_req_addr,  e_g ? p1_req_addr  : p0_req_addr);
            chk("m_req_ren",   m_req_ren,   e_g ? p1_req_ren   : 1'b1);
            chk("m_req_wen",   m_req_wen,   e_g ? p1_req_wen   : 1'b0);
            chk("m_req_flag",  m_req_flag,  e_g ? p1_req_flag  : 3'b010);
            chk("m_req_wdata", m_req_wdata, e_g ? p1_req_wdata : '0);
        end
        e_has  = !rst && (oq.size() > 0);
        e_head = e_has && (oq[0] != 0);
        e_p0v  = e_has && !e_head && m_rsp_valid;
        e_p1v  = e_has &&  e_head && m_rsp_valid;
        e_mrr  = e_has && (e_head ? p1_rsp_ready : p0_rsp_ready);
        chk("p0_rsp_valid", p0_rsp_valid, e_p0v);
        chk("p1_rsp_valid", p1_rsp_valid, e_p1v);
        chk("m_rsp_ready",  m_rsp_ready,  e_mrr);
        if (e_p0v) chk("p0_rsp_rdata", p0_rsp_rdata, m_rsp_rdata);
        if (e_p1v) chk("p1_rsp_rdata", p1_rsp_rdata, m_rsp_rdata);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            oq.delete();
            m_lock = 1'b0;
            m_rr   = 1'b1;
        end else begin
            if (e_has && m_rsp_valid && e_mrr) void'(oq.pop_front());
            if (e_mv && m_req_ready) begin
                oq.push_back(int'(e_g));
                m_lock = 1'b0;
                m_rr   = !m_rr;
            end else if (e_mv) begin
                m_lock  = 1'b1;
                m_lockp = e_g;
            end else m_lock = 1'b0;
        end
        #1;
    endtask

    task automatic drain();
        p0_req_valid = 0; p1_req_valid = 0;
        m_rsp_valid = 1; p0_rsp_ready = 1; p1_rsp_ready = 1;
        for (int i = 0; i < 8 && oq.size() > 0; i++) begin
            m_rsp_rdata = $urandom;
            settle(); tick();
        end
        m_rsp_valid = 0;
        ncmp++;
        assert (oq.size() == 0) else begin
            nerr++;
            $error("FAIL drain: observed %0d outstanding expected 0", oq.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit keep0, keep1, prev_g;
        rst = 1; m_lock = 0; m_lockp = 0; m_rr = 1;
        p0_req_valid = 0; p0_req_addr = 0; p0_rsp_ready = 0;
        p1_req_valid = 0; p1_req_ren = 0; p1_req_wen = 0; p1_req_addr = 0;
        p1_req_flag = 0; p1_req_wdata = 0; p1_rsp_ready = 0;
        m_req_ready = 0; m_rsp_valid = 0; m_rsp_rdata = 0;

        // Reset state
        settle();
        chk("rst_m_req_valid", m_req_valid, 1'b0);
        chk("rst_m_rsp_ready", m_rsp_ready, 1'b0);
        tick(); settle(); tick();
        rst = 0;

        // 1: single LSU load, response returns only to p1
        p1_req_valid = 1; p1_req_ren = 1; p1_req_wen = 0; p1_req_flag = 3'b110;
        p1_req_addr = 32'h8000_0010; p1_req_wdata = 32'h1234_5678; m_req_ready = 1;
        settle();
        chk("t1_addr", m_req_addr, 32'h8000_0010);
        tick();
        p1_req_valid = 0; m_rsp_valid = 1; m_rsp_rdata = 32'hDEAD_BEEF;
        p0_rsp_ready = 1; p1_rsp_ready = 1;
        settle();
        chk("t1_p1_rdata", p1_rsp_rdata, 32'hDEAD_BEEF);
        chk("t1_p0_valid", p0_rsp_valid, 1'b0);
        tick();

        // 2: both ports valid every cycle, responses flowing
        p0_req_valid = 1; p0_req_addr = 32'h0000_1000;
        p1_req_valid = 1; p1_req_addr = 32'h0000_2000;
        prev_g = 1'b0;
        for (int i = 0; i < 6; i++) begin
            m_rsp_rdata = i;
            settle();
`ifdef LIEAT_MEM_ARB_RR_EN
            if (i > 0) chk("t2_alternate", p1_req_ready, !prev_g);
            prev_g = p1_req_ready;
`else
            chk("t2_p1_wins", p1_req_ready, 1'b1);
            chk("t2_p0_blocked", p0_req_ready, 1'b0);
`endif
            tick();
        end
        drain();

        // 3: stalled p0 keeps the grant while p1 arrives
        p0_req_valid = 1; p0_req_addr = 32'hA000_0000; m_req_ready = 0;
        settle(); tick();
        p1_req_valid = 1; p1_req_addr = 32'hB000_0000;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t3_locked_addr", m_req_addr, 32'hA000_0000);
            chk("t3_p1_blocked", p1_req_ready, 1'b0);
            tick();
        end
        m_req_ready = 1;
        settle();
        chk("t3_p0_accept", p0_req_ready, 1'b1);
        tick();
        p0_req_valid = 0;
        settle();
        chk("t3_p1_addr", m_req_addr, 32'hB000_0000);
        chk("t3_p1_accept", p1_req_ready, 1'b1);
        tick();
        p1_req_valid = 0;

        // 4: FIFO full stalls, a pop frees the slot only on the next cycle
        p0_req_valid = 1; p0_req_addr = 32'hC000_0000;
        settle();
        chk("t4_full_stall", m_req_valid, 1'b0);
        tick();
        m_rsp_valid = 1; m_rsp_rdata = 32'h55; p0_rsp_ready = 1;
        settle();
        chk("t4_pop_p0", p0_rsp_valid, 1'b1);
        chk("t4_no_same_cycle", m_req_valid, 1'b0);
        tick();
        m_rsp_valid = 0;
        settle();
        chk("t4_issue", m_req_valid, 1'b1);
        tick();
        p0_req_valid = 0;
        drain();

        // 5: p0,p1,p0 ordering, with p1 back-pressure
        p0_req_valid = 1; p0_req_addr = 32'h10;
        settle(); tick();
        p0_req_valid = 0; p1_req_valid = 1; p1_req_addr = 32'h20;
        settle(); tick();
        p1_req_valid = 0; m_rsp_valid = 1; m_rsp_rdata = 1;
        settle();
        chk("t5_p0_gets1", p0_rsp_rdata, 32'd1);
        chk("t5_p1_idle", p1_rsp_valid, 1'b0);
        tick();
        m_rsp_valid = 0; p0_req_valid = 1; p0_req_addr = 32'h30;
        settle(); tick();
        p0_req_valid = 0; m_rsp_valid = 1; m_rsp_rdata = 2; p1_rsp_ready = 0;
        settle();
        chk("t5_hold_ready", m_rsp_ready, 1'b0);
        tick();
        p1_rsp_ready = 1;
        settle();
        chk("t5_p1_gets2", p1_rsp_rdata, 32'd2);
        tick();
        m_rsp_rdata = 3;
        settle();
        chk("t5_p0_gets3", p0_rsp_rdata, 32'd3);
        tick();
        m_rsp_valid = 0;

        // 6: reset with an outstanding request and an active lock
        p0_req_valid = 1; p0_req_addr = 32'h40;
        settle(); tick();
        p0_req_addr = 32'h44; m_req_ready = 0;
        settle(); tick();
        rst = 1;
        settle();
        chk("t6_rst_valid", m_req_valid, 1'b0);
        tick();
        rst = 0; p0_req_valid = 0; m_rsp_valid = 1; m_req_ready = 1;
        settle();
        chk("t6_cleared_ready", m_rsp_ready, 1'b0);
        chk("t6_cleared_rsp", p0_rsp_valid, 1'b0);
        tick();
        m_rsp_valid = 0;

        // Random traffic; each requester holds a pending request until accepted
        for (int n = 0; n < 2000; n++) begin
            settle();
            keep0 = p0_req_valid && !e_r0 && !rst;
            keep1 = p1_req_valid && !e_r1 && !rst;
            tick();
            rst = ($urandom_range(0, 199) == 0);
            if (!keep0) begin
                p0_req_valid = $urandom_range(0, 1);
                p0_req_addr  = $urandom;
            end
            if (!keep1) begin
                p1_req_valid = $urandom_range(0, 1);
                p1_req_ren   = $urandom_range(0, 1);
                p1_req_wen   = !p1_req_ren;
                p1_req_addr  = $urandom;
                p1_req_flag  = 3'($urandom);
                p1_req_wdata = $urandom;
            end
            m_req_ready  = ($urandom_range(0, 3) != 0);
            m_rsp_valid  = $urandom_range(0, 1);
            m_rsp_rdata  = $urandom;
            p0_rsp_ready = ($urandom_range(0, 3) != 0);
            p1_rsp_ready = ($urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
`default_nettype wire
